// File: rtl/bcd_calc_core.sv
`default_nettype none
// ============================================================================
// Module   : bcd_calc_core
// Purpose  : Calculator engine. Builds two DIGITS-wide packed-BCD operands
//            from translated key codes and runs a digit-serial BCD
//            add/subtract, one digit per cycle starting at the LSD. Supports
//            chained operators, repeat-equals, a negative-result flag and a
//            sticky overflow. The display data is taken directly from the
//            operand registers.
// Ports    : clk, resetn (async, active low)
//            key_valid/key_code/key_ready - key handshake (ready = !busy)
//            disp_bcd, disp_sel, op_out, disp_neg, overflow - display side
//            busy, result_valid - calculation status
// Revision : 1.0 - initial release
// ============================================================================
module bcd_calc_core #(
  parameter int DIGITS   = 4,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [1:0]          disp_sel,
  output logic [1:0]          op_out,
  output logic                disp_neg,
  output logic                overflow,
  output logic                busy,
  output logic                result_valid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;
  localparam logic [1:0] SEL_BLANK = 2'b00;
  localparam logic [1:0] SEL_A     = 2'b01;
  localparam logic [1:0] SEL_OP    = 2'b10;
  localparam logic [1:0] SEL_B     = 2'b11;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  state_t          post_q, post_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   calc_cnt_q, calc_cnt_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      pend_op_q, pend_op_d;
  logic [1:0]      sel_q, sel_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic            carry_q, carry_d;
  logic            rv_q, rv_d;

  // Key decode
  logic       accept, is_digit, is_op, is_clr, is_eq;
  logic [1:0] key_op;
  assign accept   = key_valid & key_ready;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == 4'hA) || (key_code == 4'hB);
  assign is_clr   = (key_code == 4'hC);
  assign is_eq    = (key_code == 4'hD);
  assign key_op   = (key_code == 4'hA) ? OP_ADD : OP_SUB;

  // Subtraction always runs larger-minus-smaller so the result is a magnitude.
  logic swap;
  assign swap = (op_q == OP_SUB) && (a_q < b_q);

  // One-digit BCD adder/subtractor with carry/borrow from the previous digit.
  logic [4:0] add_raw, sub_raw;
  logic [3:0] dig_sum;
  logic       dig_cy;
  always_comb begin
    add_raw = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'd0, carry_q};
    sub_raw = {1'b0, x_q[3:0]} - {1'b0, y_q[3:0]} - {4'd0, carry_q};
    dig_sum = add_raw[3:0];
    dig_cy  = 1'b0;
    if (op_q == OP_SUB) begin
      dig_cy  = sub_raw[4];
      dig_sum = sub_raw[4] ? (sub_raw[3:0] - 4'd6) : sub_raw[3:0];
    end else begin
      dig_cy  = (add_raw > 5'd9);
      dig_sum = dig_cy ? (add_raw[3:0] + 4'd6) : add_raw[3:0];
    end
  end

  logic   launch;
  state_t launch_post;

  always_comb begin
    state_d     = state_q;
    post_d      = post_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    calc_cnt_d  = calc_cnt_q;
    op_d        = op_q;
    pend_op_d   = pend_op_q;
    sel_d       = sel_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    rv_d        = 1'b0;
    launch      = 1'b0;
    launch_post = S_RES;

    if (state_q == S_CALC) begin
      // x doubles as the result register: each result digit enters at the
      // top while the consumed operand digit leaves at the bottom.
      x_d        = {dig_sum, x_q[W-1:4]};
      y_d        = {4'd0, y_q[W-1:4]};
      carry_d    = dig_cy;
      calc_cnt_d = calc_cnt_q + 1'b1;
      if (calc_cnt_q == CW'(DIGITS - 1)) begin
        a_d  = {dig_sum, x_q[W-1:4]};
        rv_d = 1'b1;
        if (post_q == S_OP) begin
          op_d = pend_op_q;
        end
        if ((op_q == OP_ADD) && dig_cy) begin
          ovf_d   = 1'b1;
          state_d = S_ERR;
          sel_d   = SEL_A;
        end else begin
          state_d = post_q;
          sel_d   = (post_q == S_OP) ? SEL_OP : SEL_A;
        end
      end
    end else if (accept) begin
      if (is_clr) begin
        state_d    = S_A;
        post_d     = S_A;
        a_d        = '0;
        b_d        = '0;
        x_d        = '0;
        y_d        = '0;
        cnt_d      = '0;
        calc_cnt_d = '0;
        op_d       = OP_NONE;
        pend_op_d  = OP_NONE;
        sel_d      = SEL_BLANK;
        neg_d      = 1'b0;
        ovf_d      = 1'b0;
        carry_d    = 1'b0;
      end else begin
        case (state_q)
          S_A: begin
            if (is_digit) begin
              if (cnt_q < CW'(DIGITS)) begin
                a_d   = {a_q[W-5:0], key_code};
                cnt_d = cnt_q + 1'b1;
              end
              sel_d = SEL_A;
            end else if (is_op) begin
              op_d    = key_op;
              state_d = S_OP;
              sel_d   = SEL_OP;
            end
          end
          S_OP: begin
            if (is_digit) begin
              b_d     = {{(W-4){1'b0}}, key_code};
              cnt_d   = CW'(1);
              state_d = S_B;
              sel_d   = SEL_B;
            end else if (is_op) begin
              op_d = key_op;
            end
          end
          S_B: begin
            if (is_digit) begin
              if (cnt_q < CW'(DIGITS)) begin
                b_d   = {b_q[W-5:0], key_code};
                cnt_d = cnt_q + 1'b1;
              end
            end else if (is_eq) begin
              launch      = 1'b1;
              launch_post = S_RES;
            end else if (is_op && CHAIN_EN) begin
              // The new operator only takes effect once the pending one is done.
              launch      = 1'b1;
              launch_post = S_OP;
              pend_op_d   = key_op;
            end
          end
          S_RES: begin
            if (is_digit) begin
              a_d     = {{(W-4){1'b0}}, key_code};
              cnt_d   = CW'(1);
              neg_d   = 1'b0;
              state_d = S_A;
              sel_d   = SEL_A;
            end else if (is_op && !neg_q) begin
              op_d    = key_op;
              state_d = S_OP;
              sel_d   = SEL_OP;
            end else if (is_eq && !neg_q) begin
              // Repeat-equals: previous operator applied again with retained B.
              launch      = 1'b1;
              launch_post = S_RES;
            end
          end
          default: ;
        endcase
      end
    end

    if (launch) begin
      state_d    = S_CALC;
      post_d     = launch_post;
      x_d        = swap ? b_q : a_q;
      y_d        = swap ? a_q : b_q;
      neg_d      = swap;
      carry_d    = 1'b0;
      calc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_A;
      post_q     <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      calc_cnt_q <= '0;
      op_q       <= OP_NONE;
      pend_op_q  <= OP_NONE;
      sel_q      <= SEL_BLANK;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      carry_q    <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      post_q     <= post_d;
      a_q        <= a_d;
      b_q        <= b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      calc_cnt_q <= calc_cnt_d;
      op_q       <= op_d;
      pend_op_q  <= pend_op_d;
      sel_q      <= sel_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      carry_q    <= carry_d;
      rv_q       <= rv_d;
    end
  end

  assign busy         = (state_q == S_CALC);
  assign key_ready    = !busy;
  assign disp_bcd     = (state_q == S_B) ? b_q : a_q;
  assign disp_sel     = sel_q;
  assign op_out       = op_q;
  assign disp_neg     = neg_q;
  assign overflow     = ovf_q;
  assign result_valid = rv_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_calc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_calc_core
// Purpose  : Self-checking bench for bcd_calc_core. Keys are mirrored into an
//            integer-arithmetic calculator model; each calculation pushes its
//            expected result into a queue that a monitor drains on
//            result_valid. Display state is compared before every key.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_calc_core;

  localparam int DIGITS   = 4;
  localparam bit CHAIN_EN = 1'b1;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 10 ** DIGITS;

  localparam int M_A   = 0;
  localparam int M_OP  = 1;
  localparam int M_B   = 2;
  localparam int M_RES = 3;
  localparam int M_ERR = 4;

  logic         clk;
  logic         resetn;
  logic         key_valid;
  logic [3:0]   key_code;
  logic         key_ready;
  logic [W-1:0] disp_bcd;
  logic [1:0]   disp_sel;
  logic [1:0]   op_out;
  logic         disp_neg;
  logic         overflow;
  logic         busy;
  logic         result_valid;

  bcd_calc_core #(.DIGITS(DIGITS), .CHAIN_EN(CHAIN_EN)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .disp_bcd     (disp_bcd),
    .disp_sel     (disp_sel),
    .op_out       (op_out),
    .disp_neg     (disp_neg),
    .overflow     (overflow),
    .busy         (busy),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] bcd;
    logic         neg;
    logic         ovf;
  } exp_t;
  exp_t exp_q[$];

  // Calculator model, kept as plain integers.
  int m_mode, m_a, m_b, m_cnt, m_op, m_sel;
  bit m_neg, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_mode = M_A; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_sel = 0;
    m_neg = 0; m_ovf = 0;
  endtask

  task automatic model_calc(input int post, input int newop);
    int r;
    bit n, o;
    n = 0; o = 0;
    if (m_op == 1) begin
      r = m_a + m_b;
      if (r >= MOD) begin r = r - MOD; o = 1; end
    end else if (m_a < m_b) begin
      r = m_b - m_a; n = 1;
    end else begin
      r = m_a - m_b;
    end
    m_a = r;
    m_neg = n;
    if (o) m_ovf = 1;
    exp_q.push_back('{to_bcd(r), n, m_ovf});
    if (o) begin
      m_mode = M_ERR; m_sel = 1;
    end else begin
      m_mode = post; m_sel = (post == M_OP) ? 2 : 1;
    end
    if (post == M_OP) m_op = newop;
  endtask

  task automatic model_key(input int k);
    bit dig, opk;
    dig = (k <= 9);
    opk = (k == 10) || (k == 11);
    if (k == 12) model_clear();
    else if (k < 14) begin
      case (m_mode)
        M_A: begin
          if (dig) begin
            if (m_cnt < DIGITS) begin m_a = (m_a * 10 + k) % MOD; m_cnt++; end
            m_sel = 1;
          end else if (opk) begin
            m_op = k - 9; m_mode = M_OP; m_sel = 2;
          end
        end
        M_OP: begin
          if (dig) begin m_b = k; m_cnt = 1; m_mode = M_B; m_sel = 3; end
          else if (opk) m_op = k - 9;
        end
        M_B: begin
          if (dig) begin
            if (m_cnt < DIGITS) begin m_b = (m_b * 10 + k) % MOD; m_cnt++; end
          end else if (k == 13) model_calc(M_RES, m_op);
          else if (opk && CHAIN_EN) model_calc(M_OP, k - 9);
        end
        M_RES: begin
          if (dig) begin
            m_a = k; m_cnt = 1; m_neg = 0; m_mode = M_A; m_sel = 1;
          end else if (opk && !m_neg) begin
            m_op = k - 9; m_mode = M_OP; m_sel = 2;
          end else if (k == 13 && !m_neg) model_calc(M_RES, m_op);
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_state();
    chk("disp_bcd",  32'(disp_bcd), 32'((m_mode == M_B) ? to_bcd(m_b) : to_bcd(m_a)));
    chk("disp_sel",  32'(disp_sel), 32'(m_sel));
    chk("op_out",    32'(op_out),   32'(m_op));
    chk("disp_neg",  32'(disp_neg), 32'(m_neg));
    chk("overflow",  32'(overflow), 32'(m_ovf));
    chk("busy_idle", 32'(busy),     32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (key_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: key_ready=%b expected 1", key_ready);
    end
  endtask

  // Called and returns on a falling edge; the key is accepted on the next rising edge.
  task automatic press(input int k);
    wait_idle();
    check_state();
    key_valid = 1'b1;
    key_code  = 4'(k);
    model_key(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetn && result_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rv_unexpected: result_valid=1 expected no pending result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_bcd", 32'(disp_bcd), 32'(e.bcd));
        chk("res_neg", 32'(disp_neg), 32'(e.neg));
        chk("res_ovf", 32'(overflow), 32'(e.ovf));
      end
      chk("rv_vs_busy", 32'(busy), 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t dummy;
    resetn    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_clear();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_disp_bcd", 32'(disp_bcd), 32'd0);
    chk("rst_disp_sel", 32'(disp_sel), 32'd0);
    chk("rst_op_out",   32'(op_out),   32'd0);
    chk("rst_neg",      32'(disp_neg), 32'd0);
    chk("rst_ovf",      32'(overflow), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_rv",       32'(result_valid), 32'd0);
    chk("rst_ready",    32'(key_ready), 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // 12 + 34 with busy length
    press(1); press(2); press(10); press(3); press(4); press(13);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("busy_cycles", 32'(n), 32'(DIGITS));
    chk("add_bcd", 32'(disp_bcd), 32'h0046);
    chk("add_sel", 32'(disp_sel), 32'h1);
    chk("add_neg", 32'(disp_neg), 32'h0);

    // 5 - 9 -> negative; operator key then ignored
    press(12); press(5); press(11); press(9); press(13);
    press(10);
    chk("neg_op_kept", 32'(op_out),   32'h2);
    chk("neg_bcd",     32'(disp_bcd), 32'h0004);
    chk("neg_flag",    32'(disp_neg), 32'h1);

    // 9999 + 1 -> overflow, error state ignores digits
    press(12); press(9); press(9); press(9); press(9); press(10); press(1); press(13);
    press(7);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_bcd",  32'(disp_bcd), 32'h0000);
    press(12);
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_sel", 32'(disp_sel), 32'h0);

    // Chained add and repeat-equals
    press(2); press(10); press(3); press(10);
    wait_idle();
    chk("chain_bcd", 32'(disp_bcd), 32'h0005);
    chk("chain_sel", 32'(disp_sel), 32'h2);
    press(4); press(13);
    wait_idle();
    chk("chain_res", 32'(disp_bcd), 32'h0009);
    press(13);
    wait_idle();
    chk("repeat_res", 32'(disp_bcd), 32'h0013);

    // Digit limit and key dropped while busy
    press(12); press(1); press(2); press(3); press(4); press(5);
    chk("digit_limit", 32'(disp_bcd), 32'h1234);
    press(10); press(1); press(13);
    chk("ready_busy", 32'(key_ready), 32'h0);
    key_valid = 1'b1;
    key_code  = 4'd7;
    @(negedge clk);
    key_valid = 1'b0;
    wait_idle();
    chk("drop_res", 32'(disp_bcd), 32'h1235);

    // Reset in the middle of a calculation
    press(12); press(2); press(10); press(3); press(13);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),     32'h0);
    chk("arst_disp",  32'(disp_bcd), 32'h0);
    chk("arst_op",    32'(op_out),   32'h0);
    chk("arst_ready", 32'(key_ready), 32'h1);
    model_clear();
    if (exp_q.size() > 0) dummy = exp_q.pop_back();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    press(7);
    chk("post_rst_digit", 32'(disp_bcd), 32'h0007);

    // Randomised key stream
    for (int i = 0; i < 400; i++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 58)      k = $urandom_range(0, 9);
      else if (r < 66) k = 10;
      else if (r < 73) k = 11;
      else if (r < 88) k = 13;
      else if (r < 92) k = 12;
      else             k = $urandom_range(14, 15);
      press(k);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    @(negedge clk);
    check_state();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
